// File: rtl/system_sram_arbiter.sv
// system_sram_arbiter: two-master round-robin front end for the single-port SRAM.
// Fixed one-cycle read return; out-of-range accesses are absorbed and flagged.
module system_sram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 10240
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    input  logic                  hold,
    input  logic                  err_clear,
    output logic                  err_oor,

    output logic [ADDR_W-1:0]     sram_address,
    output logic [DATA_W/8-1:0]   sram_byteenable,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [DATA_W-1:0]     sram_writedata,
    output logic                  sram_clken,
    input  logic [DATA_W-1:0]     sram_readdata
);

    localparam int              BE_W  = DATA_W / 8;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_e;

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;

    logic [ADDR_W-1:0] g_addr;
    logic [BE_W-1:0]   g_be;
    logic [DATA_W-1:0] g_wdata;
    logic              g_write;
    logic              g_oor;
    logic              rv_live;

    mst_e              last_q;
    mst_e              last_d;
    logic              rv_valid_q;
    logic              rv_valid_d;
    mst_e              rv_id_q;
    mst_e              rv_id_d;
    logic              rv_oor_q;
    logic              rv_oor_d;
    logic              err_q;
    logic              err_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Under contention the master that did not win last time gets the slot.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && !hold) begin
            if (req0 && req1) begin
                gnt0 = (last_q == MST1);
                gnt1 = (last_q == MST0);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any = gnt0 | gnt1;

    always_comb begin
        g_addr  = m0_address;
        g_be    = m0_byteenable;
        g_wdata = m0_writedata;
        g_write = m0_write;
        if (gnt1) begin
            g_addr  = m1_address;
            g_be    = m1_byteenable;
            g_wdata = m1_writedata;
            g_write = m1_write;
        end
    end

    assign g_oor = ({1'b0, g_addr} >= LIMIT);

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    assign sram_address    = g_addr;
    assign sram_byteenable = g_be;
    assign sram_writedata  = g_wdata;
    assign sram_chipselect = gnt_any & ~g_oor;
    assign sram_write      = gnt_any & ~g_oor & g_write;
    assign sram_clken      = ~hold;

    // A write wins over a simultaneous read, so only pure reads return data.
    always_comb begin
        last_d     = last_q;
        rv_valid_d = gnt_any & ~g_write;
        rv_id_d    = gnt1 ? MST1 : MST0;
        rv_oor_d   = g_oor;
        err_d      = err_q;
        if (gnt0) begin
            last_d = MST0;
        end else if (gnt1) begin
            last_d = MST1;
        end
        if (gnt_any && g_oor) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= MST1;
            rv_valid_q <= 1'b0;
            rv_id_q    <= MST0;
            rv_oor_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            rv_valid_q <= rv_valid_d;
            rv_id_q    <= rv_id_d;
            rv_oor_q   <= rv_oor_d;
            err_q      <= err_d;
        end
    end

    // A return pending when reset arrives is dropped.
    assign rv_live = rv_valid_q & ~reset;

    assign m0_readdatavalid = rv_live & (rv_id_q == MST0);
    assign m1_readdatavalid = rv_live & (rv_id_q == MST1);
    assign m0_readdata      = rv_oor_q ? '0 : sram_readdata;
    assign m1_readdata      = rv_oor_q ? '0 : sram_readdata;
    assign err_oor          = err_q;

endmodule
